// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues ibus requests and hands
// fetch_data_t {raw_instr, pc} to decode through a one-entry output register
// backed by a one-entry skid buffer.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   Defined:   a misaligned PC is not fetched; a NOP (32'h0000_0013) carrying
//              that PC is emitted with fetch_misaligned=1, and fetching stops
//              until the next redirect.
//   Undefined: misaligned PCs are fetched as-is and fetch_misaligned is absent.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   ireq_valid/addr   ibus request, held stable until iresp_data_ok
//   iresp_data_ok     one response pulse per request, data on iresp_data
//   out_valid/out     {raw_instr[95:64], pc[63:0]} towards decode
//   out_ready         decode accepts out this cycle
//   br                branch_data_t    {pc_branch[64:1], branch[0]}
//   csrf              csr_flush_data_t {pcplus4[64:1],   branch[0]}
//   fetch_misaligned  misaligned-PC flag (optional feature only)
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [95:0] out,
  input  logic        out_ready,
  input  logic [64:0] br,
  input  logic [64:0] csrf
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StDiscard, StStall} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q;
  logic        out_valid_q, out_valid_d;
  logic [95:0] out_q, out_d;
  logic [95:0] buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;

  logic        redir;
  logic [63:0] target;
  logic        slot_free;
  logic        misaligned_pc;

  // CSR/trap flush outranks an execute branch in the same cycle.
  assign redir     = csrf[0] | br[0];
  assign target    = csrf[0] ? csrf[64:1] : br[64:1];
  assign slot_free = !out_valid_q || out_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign misaligned_pc    = (pc_q[1:0] != 2'b00);
  assign fetch_misaligned = mis_q;
`else
  assign misaligned_pc = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q       <= mis_d;
`endif
      // Track the issuing PC while in REQ so DISCARD keeps presenting the
      // address of the request still in flight after pc_q has moved on.
      if (state_q == StReq) begin
        req_addr_q <= pc_q;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d       = mis_q;
`endif

    // Consume; may be overridden by a refill below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end

      StReq: begin
        if (misaligned_pc) begin
          // No bus request; emit a NOP tagged with the faulting PC and park.
          if (!redir && slot_free) begin
            out_d       = {32'h0000_0013, pc_q};
            out_valid_d = 1'b1;
            state_d     = StStall;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_d       = 1'b1;
`endif
          end
        end else if (iresp_data_ok) begin
          if (!redir) begin
            pc_d = pc_q + 64'd4;
            if (slot_free) begin
              out_d       = {iresp_data, pc_q};
              out_valid_d = 1'b1;
            end else begin
              buf_d       = {iresp_data, pc_q};
              buf_valid_d = 1'b1;
              state_d     = StStall;
            end
          end
        end else if (redir) begin
          state_d = StDiscard;
        end
      end

      StDiscard: begin
        if (iresp_data_ok) begin
          state_d = StReq;
        end
      end

      StStall: begin
        if (redir) begin
          state_d = StReq;
        end else if (buf_valid_q && slot_free) begin
          out_d       = buf_q;
          out_valid_d = 1'b1;
          buf_valid_d = 1'b0;
          state_d     = StReq;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // A redirect squashes everything younger and retargets the PC.
    if (redir) begin
      pc_d        = target;
      out_valid_d = 1'b0;
      buf_valid_d = 1'b0;
      if (state_q == StStall) begin
        state_d = StReq;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_d       = 1'b0;
`endif
    end
  end

  // Outputs.
  always_comb begin
    ireq_valid = ((state_q == StReq) && !misaligned_pc) || (state_q == StDiscard);
    ireq_addr  = (state_q == StDiscard) ? req_addr_q : pc_q;
    out_valid  = out_valid_q;
    out        = out_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [63:0] ResetPc = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [95:0] out_data;
  logic        out_ready;
  logic [64:0] br;
  logic [64:0] csrf;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  fetch_unit #(.RESET_PC(ResetPc)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .out_valid     (out_valid),
    .out           (out_data),
    .out_ready     (out_ready),
    .br            (br),
    .csrf          (csrf)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  // Bus responder controls.
  bit rsp_en = 1'b1;
  bit rsp_force = 1'b0;
  int rsp_min = 1;
  int rsp_max = 1;

  // Bus responder: answers each request after a random number of cycles.
  initial begin
    int cnt = 0;
    int wait_tgt = 1;
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_force) begin
        iresp_data_ok = 1'b1;
        iresp_data    = mem(ireq_addr);
        cnt = 0;
      end else if (!reset) begin
        iresp_data_ok = 1'b0;
        cnt = 0;
      end else if (ireq_valid && rsp_en) begin
        if (cnt >= wait_tgt) begin
          iresp_data_ok = 1'b1;
          iresp_data    = mem(ireq_addr);
          cnt = 0;
          wait_tgt = $urandom_range(rsp_max, rsp_min);
        end else begin
          iresp_data_ok = 1'b0;
          cnt++;
        end
      end else begin
        iresp_data_ok = 1'b0;
      end
    end
  end

  // Reference model: program-order PC stream with redirects. Pushes the
  // expected decode stream into the scoreboard and checks bus behaviour.
  initial begin
    logic [63:0] m_fetch_pc = ResetPc;
    logic [63:0] m_req_addr = '0;
    logic [63:0] m_lat_pc = '0;
    logic [63:0] tgt;
    bit m_in_req = 0, m_stale = 0, m_trapped = 0, m_lat_pend = 0, m_squash = 0;
    bit redir;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        m_fetch_pc = ResetPc;
        m_in_req = 0; m_stale = 0; m_trapped = 0; m_lat_pend = 0; m_squash = 0;
        sb.delete();
        continue;
      end
      redir = br[0] | csrf[0];
      tgt   = csrf[0] ? csrf[64:1] : br[64:1];

      if (m_squash) begin
        chk(!out_valid, "squash_after_redir", 96'(out_valid), 96'(0));
        m_squash = 0;
      end
      if (m_lat_pend) begin
        chk(out_valid && out_data[63:0] == m_lat_pc, "latency_pc",
            {31'(0), out_valid, out_data[63:0]}, {32'(1), m_lat_pc});
        m_lat_pend = 0;
      end

      if (ireq_valid && !m_in_req) begin
        chk(ireq_addr == m_fetch_pc, "issue_addr", 96'(ireq_addr), 96'(m_fetch_pc));
        chk(!m_trapped, "req_while_trapped", 96'(1), 96'(0));
        m_in_req   = 1;
        m_req_addr = ireq_addr;
      end else if (ireq_valid) begin
        chk(ireq_addr == m_req_addr, "addr_stable", 96'(ireq_addr), 96'(m_req_addr));
      end

      if (iresp_data_ok && ireq_valid) begin
        m_in_req = 0;
        if (!redir && !m_stale) begin
          sb.push_back('{instr: mem(m_req_addr), pc: m_req_addr, mis: 1'b0});
          m_fetch_pc = m_fetch_pc + 64'd4;
          if (!out_valid || out_ready) begin
            m_lat_pend = 1;
            m_lat_pc   = m_req_addr;
          end
        end
        m_stale = 0;
      end

      if (redir) begin
        if (m_in_req) m_stale = 1;
        m_fetch_pc = tgt;
        m_trapped  = 0;
        m_squash   = 1;
        sb.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) begin
          m_trapped = 1;
          sb.push_back('{instr: 32'h0000_0013, pc: tgt, mis: 1'b1});
        end
`endif
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready && !(br[0] | csrf[0])) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_out", out_data, 96'(0));
        end else begin
          e = sb.pop_front();
          chk(out_data == {e.instr, e.pc}, "out_data", out_data, {e.instr, e.pc});
`ifdef FETCH_MISALIGN_TRAP_EN
          chk(fetch_misaligned == e.mis, "mis_flag", 96'(fetch_misaligned), 96'(e.mis));
`endif
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (ireq_valid) return;
    end
    chk(1'b0, "wait_req_timeout", 96'(0), 96'(1));
  endtask

  task automatic wait_out();
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (out_valid) return;
    end
    chk(1'b0, "wait_out_timeout", 96'(0), 96'(1));
  endtask

  initial begin
    reset = 1'b0; out_ready = 1'b0; br = '0; csrf = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(!ireq_valid, "reset_ireq_valid", 96'(ireq_valid), 96'(0));
    chk(!out_valid, "reset_out_valid", 96'(out_valid), 96'(0));
    chk(out_data == '0, "reset_out", out_data, 96'(0));

    // Straight-line fetch, one-cycle response latency, decode always ready.
    @(posedge clk);
    #2;
    reset = 1'b1; out_ready = 1'b1;
    repeat (12) cycle();

    // Decode backpressure: second response is buffered, bus goes quiet.
    wait_out();
    out_ready = 1'b0;
    repeat (3) cycle();
    chk(!ireq_valid, "stall_no_req", 96'(ireq_valid), 96'(0));
    out_ready = 1'b1;
    repeat (8) cycle();

    // Branch redirect while a request is pending.
    rsp_en = 1'b0;
    wait_req();
    br = {64'h0000_0000_8000_0100, 1'b1};
    cycle();
    br = '0;
    repeat (3) cycle();
    chk(ireq_valid, "discard_holds_req", 96'(ireq_valid), 96'(1));
    rsp_en = 1'b1;
    repeat (10) cycle();

    // CSR and branch redirects together with the response.
    rsp_en = 1'b0;
    wait_req();
    rsp_force = 1'b1;
    cycle();
    rsp_force = 1'b0;
    csrf = {64'h0000_0000_8000_0200, 1'b1};
    br   = {64'h0000_0000_8000_0300, 1'b1};
    cycle();
    csrf = '0; br = '0;
    rsp_en = 1'b1;
    repeat (10) cycle();

    // Reset mid-transaction, then a stale response during IDLE.
    rsp_en = 1'b0;
    wait_req();
    #1;
    reset = 1'b0;
    #1;
    chk(!ireq_valid, "async_reset_ireq", 96'(ireq_valid), 96'(0));
    chk(!out_valid, "async_reset_out_valid", 96'(out_valid), 96'(0));
    rsp_force = 1'b1;
    cycle();
    reset = 1'b1;
    rsp_force = 1'b0;
    repeat (2) cycle();
    chk(!out_valid, "stale_ok_ignored", 96'(out_valid), 96'(0));
    rsp_en = 1'b1;
    repeat (10) cycle();

`ifdef FETCH_MISALIGN_TRAP_EN
    br = {64'h0000_0000_8000_0102, 1'b1};
    cycle();
    br = '0;
    repeat (10) cycle();
    chk(fetch_misaligned, "trap_flag_set", 96'(fetch_misaligned), 96'(1));
    chk(!ireq_valid, "trap_no_req", 96'(ireq_valid), 96'(0));
    csrf = {64'h0000_0000_8000_0400, 1'b1};
    cycle();
    csrf = '0;
    cycle();
    chk(!fetch_misaligned, "trap_flag_clear", 96'(fetch_misaligned), 96'(0));
    repeat (10) cycle();
`endif

    // Randomized traffic: variable latency, backpressure and redirects.
    rsp_min = 0;
    rsp_max = 3;
    for (int i = 0; i < 800; i++) begin
      out_ready = ($urandom_range(3, 0) != 0);
      br = '0;
      csrf = '0;
      if ($urandom_range(19, 0) == 0) begin
        if ($urandom_range(7, 0) == 0) br = {64'hFFFF_FFFF_FFFF_FFF8, 1'b1};
        else br = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFC), 1'b1};
      end
      if ($urandom_range(39, 0) == 0) begin
        csrf = {32'h0, 32'h8000_1000 | ($urandom & 32'h0000_0FFC), 1'b1};
      end
      cycle();
    end
    br = '0; csrf = '0; out_ready = 1'b1;
    repeat (10) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end. Owns the PC, acts as ibus initiator, and produces fetch_data_t {raw_instr, pc} for decode.
- Accepts redirects from two sources: branch_data_t from execute, and csr_flush_data_t from the CSR/trap path on mret, ecall or a csr write.
- Drops responses to fetches that a redirect has made stale, and stalls on decode backpressure.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC of the first fetch after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ireq_valid  out  1  instruction fetch request
- ireq_addr  out  64  fetch address, equal to the current PC
- iresp_data_ok  in  1  response valid; one pulse per request
- iresp_data  in  32  instruction word
- out_valid  out  1  out holds a valid instruction
- out  out  96  fetch_data_t {raw_instr[95:64], pc[63:0]}
- out_ready  in  1  decode accepts out this cycle
- br  in  65  branch_data_t {pc_branch, branch}; redirect when branch=1
- csrf  in  65  csr_flush_data_t {pcplus4, branch}; redirect when branch=1
- fetch_misaligned  out  1  misaligned-PC flag; exists only under the optional feature

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC.
  - out_valid=0, out=0, ireq_valid=0, buffer empty.
- Redirect:
  - redir = csrf.branch | br.branch.
  - Target = csrf.pcplus4 if csrf.branch, else br.pc_branch. The CSR path has priority.
  - On redir the unit always does all of the following:
    - pc <= target.
    - out_valid <= 0 (the younger instruction is squashed, even if out_ready=1 this cycle).
    - buffer cleared.
- ibus rule: once ireq_valid=1, ireq_valid and ireq_addr stay stable until the cycle of iresp_data_ok.
- Outputs:
  - ireq_valid = (state==REQ) | (state==DISCARD).
  - ireq_addr = the PC latched at issue.
  - Back-to-back requests are allowed.
- Slot free = !out_valid | out_ready.
- Consume: out_valid & out_ready & !redir gives out_valid <= 0, unless it is refilled in the same cycle.
- IDLE:
  - Lasts one cycle after reset deassertion, then goes to REQ.
  - redir in IDLE updates pc only.
- REQ:
  - iresp_data_ok & redir: drop data, go to REQ; the next request uses the target PC.
  - iresp_data_ok & slot free: out <= {iresp_data, pc}, out_valid <= 1, pc <= pc+4, stay in REQ.
  - iresp_data_ok & slot busy: store {data, pc} in the buffer, pc <= pc+4, go to STALL.
  - !iresp_data_ok & redir: go to DISCARD; ireq_addr stays the old PC.
- DISCARD:
  - Wait for iresp_data_ok, drop the data, then go to REQ with the current pc.
  - Further redirects in DISCARD only update pc.
- STALL:
  - ireq_valid=0.
  - When the slot is free: out <= buffer, out_valid <= 1, go to REQ.
  - redir: clear the buffer, go to REQ.
- Latency: out_valid rises on the cycle after iresp_data_ok.
- Throughput: one instruction per bus transaction.
- Arithmetic: pc+4 is a 64-bit add, wrapping modulo 2^64.
- Reset asserted mid-transaction: everything returns to reset values immediately. A late iresp_data_ok after reset is ignored, because IDLE ignores data_ok.
- Simultaneous iresp_data_ok, out_ready and redir: redir wins. Nothing is latched and out_valid <= 0.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: if pc[1:0] != 0 in REQ before issue, there is no bus request.
  - out <= {32'h0000_0013, pc}, out_valid <= 1, fetch_misaligned=1 with out.
  - The unit then idles in STALL until a redirect.
  - fetch_misaligned resets to 0 and clears on redirect.
- Undefined:
  - The port is absent.
  - Misaligned PCs are fetched as-is, with ireq_addr = pc.

Test Plan:
- Reset release, iresp_data_ok one cycle after each request, out_ready=1 -> ireq_addr 0x8000_0000, 0x8000_0004, 0x8000_0008; out.pc matches, one cycle after each data_ok.
- out_ready=0 for 3 cycles after the first instruction -> second response is buffered; ireq_valid=0 in STALL; out.pc=0x8000_0004 appears the cycle after out_ready=1.
- br={0x8000_0100,1} while a request to 0x8000_0008 is pending -> ireq_addr stays 0x8000_0008 until data_ok; that data is dropped; next request is 0x8000_0100.
- csrf={0x8000_0200,1} and br={0x8000_0300,1} in the same cycle as iresp_data_ok -> out_valid=0; next request is 0x8000_0200.
- reset driven low while a request is pending, then released -> ireq_valid=0 and out_valid=0 immediately; first post-reset request is RESET_PC; a stale data_ok during IDLE produces no output.
- With FETCH_MISALIGN_TRAP_EN, br={0x8000_0102,1} -> no ireq; out.pc=0x8000_0102, fetch_misaligned=1; a subsequent csrf redirect clears the flag and fetching resumes.
